// File: rtl/pdm_speaker.sv
// Wishbone PCM-to-PDM transmitter: a sample FIFO feeds a first-order sigma-delta
// modulator that drives a 1-bit PDM stream and bit clock to an external amplifier.
module pdm_speaker #(
  parameter int WB_HZ      = 48_000_000,
  parameter int PDM_HZ     = 3_000_000,
  parameter int AUDIO_BITS = 16,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat_i,
  output logic [31:0] o_wb_dat_o,
  output logic        o_wb_ack,
  output logic        o_pdm_clk,
  output logic        o_pdm_data,
  output logic        o_irq
);

  localparam int TICKS = WB_HZ / PDM_HZ / 2;
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int OBW   = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  logic                  r_ack;
  logic [31:0]           r_dat_o;
  logic                  r_en;
  logic [7:0]            r_thresh;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  r_irq;
  logic [AUDIO_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [LW-1:0]         r_head;
  logic [LW-1:0]         r_tail;
  logic [CW-1:0]         r_cnt;
  logic                  r_pdm_clk;
  logic                  r_pdm_data;
  logic [AUDIO_BITS:0]   r_acc;
  logic [OBW-1:0]        r_bitcnt;
  logic [AUDIO_BITS-1:0] r_sample;

  logic                  w_req, w_wr;
  logic                  w_data_wr, w_status_wr, w_ctrl_wr;
  logic [LW-1:0]         w_level;
  logic [7:0]            w_level8;
  logic                  w_empty, w_full;
  logic                  w_push, w_ovf_set;
  logic                  w_en_nxt, w_run, w_tick, w_step, w_fetch;
  logic                  w_pop, w_unf_set;
  logic [AUDIO_BITS-1:0] w_cur;
  logic [AUDIO_BITS-1:0] w_u;
  logic [AUDIO_BITS:0]   w_sum;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_req       = i_wb_stb & ~r_ack;
  assign w_wr        = w_req & i_wb_we;
  assign w_data_wr   = w_wr & (i_wb_adr == ADR_DATA);
  assign w_status_wr = w_wr & (i_wb_adr == ADR_STATUS);
  assign w_ctrl_wr   = w_wr & (i_wb_adr == ADR_CTRL);

  assign w_level   = r_tail - r_head;
  assign w_level8  = 8'(w_level);
  assign w_empty   = (w_level == {LW{1'b0}});
  assign w_full    = (w_level == LW'(FIFO_DEPTH));
  assign w_push    = w_data_wr & ~w_full;
  assign w_ovf_set = w_data_wr & w_full;

  // Disabling takes effect in the same cycle as the CTRL write, not one later.
  assign w_en_nxt  = w_ctrl_wr ? i_wb_dat_i[0] : r_en;
  assign w_run     = r_en & w_en_nxt;
  assign w_tick    = w_run & (r_cnt == CW'(TICKS - 1));
  assign w_step    = w_tick & r_pdm_clk;
  assign w_fetch   = w_step & (r_bitcnt == {OBW{1'b0}});
  assign w_pop     = w_fetch & ~w_empty;
  assign w_unf_set = w_fetch & w_empty;

  assign w_u   = {~w_cur[AUDIO_BITS-1], w_cur[AUDIO_BITS-2:0]};
  assign w_sum = {1'b0, r_acc[AUDIO_BITS-1:0]} + {1'b0, w_u};

  assign w_unused = ^i_wb_dat_i;

  // Sample used by this modulator step: fresh FIFO head (or midscale) at OSR boundaries.
  always_comb begin
    w_cur = r_sample;
    if (r_bitcnt != {OBW{1'b0}}) begin
      w_cur = r_sample;
    end else if (w_empty) begin
      w_cur = {AUDIO_BITS{1'b0}};
    end else begin
      w_cur = r_mem[r_head[AW-1:0]];
    end
  end

  // Register read mux.
  always_comb begin
    w_rdata = 32'd0;
    case (i_wb_adr)
      ADR_STATUS: w_rdata = {16'd0, w_level8, 5'd0, r_unf, r_ovf, w_empty};
      ADR_CTRL:   w_rdata = {16'd0, r_thresh, 7'd0, r_en};
      default:    w_rdata = 32'd0;
    endcase
  end

  // Bus handshake, read data and CTRL register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_dat_o  <= 32'd0;
      r_en     <= 1'b0;
      r_thresh <= 8'd0;
    end else begin
      r_ack    <= w_req;
      r_dat_o  <= (w_req & ~i_wb_we) ? w_rdata : 32'd0;
      r_en     <= w_en_nxt;
      r_thresh <= w_ctrl_wr ? i_wb_dat_i[15:8] : r_thresh;
    end
  end

  // Sticky flags (set beats W1C) and the level interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovf_set)                          r_ovf <= 1'b1;
      else if (w_status_wr & i_wb_dat_i[1])   r_ovf <= 1'b0;
      else                                    r_ovf <= r_ovf;
      if (w_unf_set)                          r_unf <= 1'b1;
      else if (w_status_wr & i_wb_dat_i[2])   r_unf <= 1'b0;
      else                                    r_unf <= r_unf;
      r_irq <= r_en & ((w_level8 <= r_thresh) | r_unf);
    end
  end

  // FIFO pointers; the extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= {LW{1'b0}};
      r_tail <= {LW{1'b0}};
    end else begin
      r_tail <= w_push ? r_tail + LW'(1) : r_tail;
      r_head <= w_pop  ? r_head + LW'(1) : r_head;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail[AW-1:0]] <= i_wb_dat_i[AUDIO_BITS-1:0];
    end
  end

  // Clock divider and sigma-delta step on the falling PDM clock.
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_cnt      <= {CW{1'b0}};
      r_pdm_clk  <= 1'b0;
      r_pdm_data <= 1'b0;
      r_acc      <= {(AUDIO_BITS+1){1'b0}};
      r_bitcnt   <= {OBW{1'b0}};
    end else if (w_tick) begin
      r_cnt     <= {CW{1'b0}};
      r_pdm_clk <= ~r_pdm_clk;
      if (r_pdm_clk) begin
        r_acc      <= w_sum;
        r_pdm_data <= w_sum[AUDIO_BITS];
        r_bitcnt   <= r_bitcnt + OBW'(1);
      end else begin
        r_acc      <= r_acc;
        r_pdm_data <= r_pdm_data;
        r_bitcnt   <= r_bitcnt;
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Current PCM sample, survives EN=0 but not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= {AUDIO_BITS{1'b0}};
    end else if (w_step) begin
      r_sample <= w_cur;
    end else begin
      r_sample <= r_sample;
    end
  end

  assign o_wb_ack   = r_ack;
  assign o_wb_dat_o = r_dat_o;
  assign o_pdm_clk  = r_pdm_clk;
  assign o_pdm_data = r_pdm_data;
  assign o_irq      = r_irq;

endmodule

// File: doc/pdm_speaker.md
Name: pdm_speaker

Overview:
- Wishbone peripheral. Takes signed PCM samples from the CPU and drives a 1-bit PDM stream plus PDM clock to an external amplifier/speaker.
- It is the transmit-side counterpart of the PDM microphone input: CPU writes samples into a small FIFO, and a first-order sigma-delta modulator converts them to PDM at PDM_HZ.
- Raises an interrupt when the FIFO needs refilling.

Parameters:
- WB_HZ, 48000000, system/Wishbone clock frequency in Hz.
- PDM_HZ, 3000000, PDM bit clock frequency in Hz. TICKS = WB_HZ/PDM_HZ/2 must be >= 1 (formal assert).
- AUDIO_BITS, 16, PCM sample width, signed two's complement.
- OSR, 64, PDM bits per PCM sample. Must be a power of two.
- FIFO_DEPTH, 8, sample FIFO entries. Must be a power of two, >= 2.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- wb_stb, in, 1, Wishbone strobe (cyc qualified upstream).
- wb_we, in, 1, write enable.
- wb_adr, in, 2, word address.
- wb_dat_i, in, 32, write data.
- wb_dat_o, out, 32, read data.
- wb_ack, out, 1, acknowledge.
- pdm_clk, out, 1, PDM clock to amplifier.
- pdm_data, out, 1, PDM data, stable around rising pdm_clk.
- irq, out, 1, level interrupt.

Behaviour:
- Reset: pdm_clk=0, pdm_data=0, wb_ack=0, wb_dat_o=0, irq=0. FIFO empty, all sticky flags 0, CTRL=0, accumulator=0, bit counter=0, current sample=0.
- Bus handshake: wb_ack=1 exactly one cycle after any cycle with wb_stb=1 and wb_ack=0. It then drops for one cycle, so back-to-back transactions complete every 2 cycles. Side effects occur once, in the cycle stb is sampled with ack=0.
- Read data appears on wb_dat_o in the ack cycle. Unmapped addresses read 0; writes to them are ignored.
- Address map:
  - 0 DATA, write-only: push wb_dat_i[AUDIO_BITS-1:0] into the FIFO. If the FIFO is full, the write is dropped and OVF is set. Reads return 0.
  - 1 STATUS: read {16'b0, level[7:0], 5'b0, UNF, OVF, EMPTY}. Writing 1 to bit1 clears OVF; writing 1 to bit2 clears UNF (W1C). A set event and a clear in the same cycle: set wins.
  - 2 CTRL, read/write: bit0 EN, bits[15:8] THRESH.
- Clock divider: counter 0..TICKS-1. At TICKS-1 the counter wraps to 0 and pdm_clk toggles. The divider runs only when EN=1. When EN=0: pdm_clk held 0, pdm_data held 0, counter=0, accumulator=0, bit counter=0, FIFO contents preserved.
- Modulator step: occurs in the cycle pdm_clk toggles 1->0, so the data changes half a PDM period before the amplifier's rising-edge sample.
  - u = current sample with MSB inverted (offset binary, AUDIO_BITS wide).
  - acc (AUDIO_BITS+1 bits): acc <= {1'b0, acc[AUDIO_BITS-1:0]} + u. pdm_data <= carry bit of that sum, registered.
  - Result: duty cycle = u/2^AUDIO_BITS; 0x0000 signed gives 50%.
- Sample fetch: bit counter counts modulator steps modulo OSR.
  - On the step where the counter is 0 (including the first step after EN rises), pop the FIFO head into the current sample before computing u.
  - If the FIFO is empty at that point, the current sample becomes 0 (midscale) and UNF is set.
- FIFO: head/tail pointers with one extra wrap bit; level = tail-head, range 0..FIFO_DEPTH.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - A push to a full FIFO is dropped even if a pop occurs in the same cycle.
- IRQ: irq = EN & ((level <= THRESH) | UNF), registered, one cycle latency.
- Reset mid-operation: all state returns to reset values the next cycle, including dropping pdm_clk and discarding the FIFO.

Test Plan:
- Bus: read STATUS after reset -> 0x00000001 (EMPTY). Ack exactly 1 cycle after stb; ack low on the following cycle even if stb stays high.
- Clock: WB_HZ=12 MHz, PDM_HZ=3 MHz, EN=1 -> pdm_clk period 4 clk cycles, 50% duty. EN=0 -> pdm_clk=0 within 1 cycle.
- Modulation: OSR=64, AUDIO_BITS=16, push 0x4000 repeatedly -> 48 ones per 64 PDM bits (±1). Push 0x8000 -> all 0. Push 0x7FFF -> 63 or 64 ones. Push 0x0000 -> 32 ones, alternating pattern.
- FIFO: DEPTH=8, EN=0, write 9 samples -> level=8, OVF=1. Write 0x2 to STATUS -> OVF=0. A simultaneous OVF set event and W1C clear -> OVF stays 1.
- Underrun and IRQ: THRESH=2, EN=1, one sample queued -> irq=1 immediately. After the FIFO drains at the next OSR boundary -> UNF=1, pdm_data toggles 50%. Push 4 samples and W1C UNF -> irq=0 once level>2.
- Reset mid-stream with EN=1 and a full FIFO: assert rst 1 cycle -> next cycle pdm_clk=0, irq=0, STATUS reads EMPTY, CTRL=0.
